alu_sequencer: RTL and testbench

Single-issue controller that sequences the 16-bit ALU in the microcpu datapath. It accepts one ALU command at a time over a valid/ready handshake and reads the operands from an internal register file. It drives the ALU ports, waits a fixed number of cycles, writes the result back to the register file and returns it over a valid/ready response channel. The ALU itself is instantiated alongside this block; the sequencer only connects to its a, b, imm_val, imm, func and out ports.

---
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue controller for the external 16-bit ALU. It reads operands
// from an internal register file, waits ALU_LAT cycles, writes back and returns the result.
module alu_sequencer #(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned ALU_LAT = 1,
  localparam int unsigned RW     = $clog2(NREGS),
  localparam int unsigned DW     = 16,
  localparam int unsigned FW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [FW-1:0] cmd_func,
  input  logic          cmd_imm,
  input  logic [DW-1:0] cmd_imm_val,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_imm_val,
  output logic          alu_imm,
  output logic [FW-1:0] alu_func,
  input  logic [DW-1:0] alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [RW-1:0] rsp_rd,
  output logic          busy,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] regs [NREGS];
  logic          accept_c;
  logic          done_c;
  logic          release_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c)  state_nxt = S_EXEC;
      S_EXEC:  if (done_c)    state_nxt = S_RESP;
      S_RESP:  if (release_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes: command accept, result sample, response release
  always_comb begin
    accept_c  = 1'b0;
    done_c    = 1'b0;
    release_c = 1'b0;
    case (state)
      S_IDLE:  accept_c  = cmd_valid & cmd_ready;
      S_EXEC:  done_c    = (cnt == CW'(1));
      S_RESP:  release_c = rsp_valid & rsp_ready;
      default: ;
    endcase
  end

  // ALU drive, latency counter and response registers; handshake flags track the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_imm_val <= '0;
      alu_imm     <= 1'b0;
      alu_func    <= '0;
      rd_q        <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
    end else begin
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      if (accept_c) begin
        alu_a       <= regs[cmd_ra];
        alu_b       <= regs[cmd_rb];
        alu_imm_val <= cmd_imm_val;
        alu_imm     <= cmd_imm;
        alu_func    <= cmd_func;
        rd_q        <= cmd_rd;
        cnt         <= CW'(ALU_LAT);
      end else if (state == S_EXEC) begin
        cnt <= cnt - CW'(1);
      end
      if (done_c) begin
        rsp_data <= alu_out;
        rsp_rd   <= rd_q;
      end
      if (done_c) begin
        rsp_valid <= 1'b1;
      end else if (release_c) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (done_c && (rd_q != '0)) begin
      regs[rd_q] <= alu_out;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: attaches a behavioural ALU, runs a vector table,
// multi-cycle corner sequences and random commands against a register-file model.
module tb_alu_sequencer;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned ALU_LAT = 3;
  localparam int unsigned RW      = 3;
  localparam int          CP      = 10;

  typedef struct packed {
    logic [3:0]    func;
    logic          imm;
    logic [15:0]   imm_val;
    logic [RW-1:0] rd;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
  } cmd_t;

  typedef struct packed {
    cmd_t        c;
    logic [15:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_func = '0;
  logic          cmd_imm = 1'b0;
  logic [15:0]   cmd_imm_val = '0;
  logic [RW-1:0] cmd_rd = '0;
  logic [RW-1:0] cmd_ra = '0;
  logic [RW-1:0] cmd_rb = '0;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [15:0]   alu_imm_val;
  logic          alu_imm;
  logic [3:0]    alu_func;
  logic [15:0]   alu_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_data;
  logic [RW-1:0] rsp_rd;
  logic          busy;
  logic [RW-1:0] dbg_addr = '0;
  logic [15:0]   dbg_data;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] model [NREGS];
  time         prev_done = 0;
  bit          have_prev = 1'b0;
  vec_t        vecs [9];

  alu_sequencer #(.NREGS(NREGS), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_imm(cmd_imm),
    .cmd_imm_val(cmd_imm_val), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm_val(alu_imm_val), .alu_imm(alu_imm),
    .alu_func(alu_func), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #(CP/2) clk = ~clk;

  // Behavioural ALU: operand is imm_val in immediate mode, else a; combined with b
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] iv, input logic imm,
                                         input logic [3:0] f);
    logic [15:0] o;
    logic [15:0] r;
    o = imm ? iv : a;
    case (f)
      4'd0:    r = o;
      4'd1:    r = b + o;
      4'd2:    r = b - o;
      4'd3:    r = b & o;
      4'd4:    r = b ^ o;
      4'd5:    r = b | o;
      default: r = ~o;
    endcase
    return r;
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_imm_val, alu_imm, alu_func);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NREGS); i++) model[i] = 16'h0;
    have_prev = 1'b0;
  endtask

  task automatic offer(input cmd_t c);
    cmd_func    = c.func;
    cmd_imm     = c.imm;
    cmd_imm_val = c.imm_val;
    cmd_rd      = c.rd;
    cmd_ra      = c.ra;
    cmd_rb      = c.rb;
    cmd_valid   = 1'b1;
  endtask

  // Called just after an edge; cmd_ready then holds the value seen at the next edge
  task automatic wait_accept(output time t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        t = $time;
        #1;
        cmd_valid = 1'b0;
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: command not accepted within 40 cycles at t=%0t", $time);
    end
  endtask

  task automatic dbg_all_zero(input string name);
    for (int i = 0; i < int'(NREGS); i++) begin
      dbg_addr = RW'(i);
      #1;
      chk(name, 128'(dbg_data), 128'(16'h0));
    end
    tick();
  endtask

  // Follow an accepted command through EXEC and RESP, optionally stalling rsp_ready
  task automatic finish_cmd(input cmd_t c, input int stall, input logic [15:0] exp,
                            input time t_acc, input bit has_next, input cmd_t nxt,
                            output time t_done);
    logic [52:0] exp_alu;
    bit          seen;
    time         t_v;
    seen    = 1'b0;
    t_v     = 0;
    exp_alu = {model[c.ra], model[c.rb], c.imm_val, c.imm, c.func};
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        t_v  = $time - 1;
      end else begin
        chk("alu_hold", 128'({alu_a, alu_b, alu_imm_val, alu_imm, alu_func}), 128'(exp_alu));
        tick();
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never rose at t=%0t", $time);
      t_done = $time;
      return;
    end
    chk("latency", 128'(t_v - t_acc), 128'(ALU_LAT * CP));
    chk("rsp_data", 128'(rsp_data), 128'(exp));
    chk("rsp_rd", 128'(rsp_rd), 128'(c.rd));
    for (int k = 0; k < stall; k++) begin
      if (k == 0 && has_next) offer(nxt);
      tick();
      chk("stall_hold", 128'({rsp_valid, cmd_ready, busy, rsp_rd, rsp_data}),
          128'({1'b1, 1'b0, 1'b1, c.rd, exp}));
    end
    if (stall == 0 && has_next) offer(nxt);
    rsp_ready = 1'b1;
    @(posedge clk);
    t_done = $time;
    #1;
    chk("release", 128'({rsp_valid, busy, cmd_ready, rsp_data}), 128'({3'b001, exp}));
    if (c.rd != '0) model[c.rd] = exp;
    dbg_addr = c.rd;
    #1;
    chk("dbg_rd", 128'(dbg_data), 128'((c.rd == '0) ? 16'h0 : exp));
  endtask

  task automatic run_cmd(input cmd_t c, input int stall, input logic [15:0] exp);
    time  t_acc;
    time  t_done;
    bit   ok;
    cmd_t none;
    none = '0;
    rsp_ready = (stall == 0);
    offer(c);
    wait_accept(t_acc, ok);
    if (!ok) return;
    if (have_prev) chk("issue_gap", 128'(t_acc - prev_done), 128'(CP));
    finish_cmd(c, stall, exp, t_acc, 1'b0, none, t_done);
    prev_done = t_done;
    have_prev = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_t        c1;
    cmd_t        c2;
    cmd_t        none;
    logic [15:0] e1;
    logic [15:0] e2;
    time         t1;
    time         t2;
    time         td;
    bit          ok;

    // func, imm, imm_val, rd, ra, rb -> expected result
    vecs[0] = '{'{4'd0, 1'b1, 16'h1200, 3'd1, 3'd0, 3'd0}, 16'h1200};
    vecs[1] = '{'{4'd5, 1'b1, 16'h0034, 3'd2, 3'd0, 3'd1}, 16'h1234};
    vecs[2] = '{'{4'd1, 1'b0, 16'h0000, 3'd3, 3'd1, 3'd2}, 16'h2434};
    vecs[3] = '{'{4'd2, 1'b0, 16'h0000, 3'd4, 3'd2, 3'd3}, 16'h1200};
    vecs[4] = '{'{4'd1, 1'b1, 16'hFFFF, 3'd5, 3'd0, 3'd0}, 16'hFFFF};
    vecs[5] = '{'{4'd1, 1'b1, 16'h0001, 3'd6, 3'd0, 3'd5}, 16'h0000};
    vecs[6] = '{'{4'd0, 1'b1, 16'hBEEF, 3'd0, 3'd0, 3'd0}, 16'hBEEF};
    vecs[7] = '{'{4'd4, 1'b0, 16'h0000, 3'd7, 3'd5, 3'd2}, 16'hEDCB};
    vecs[8] = '{'{4'd5, 1'b0, 16'h0000, 3'd1, 3'd7, 3'd3}, 16'hEDFF};
    none = '0;

    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_during_ctrl", 128'({cmd_ready, busy, rsp_valid}), 128'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ctrl", 128'({cmd_ready, busy, rsp_valid, rsp_rd}), 128'({3'b100, 3'd0}));
    chk("rst_alu", 128'({alu_a, alu_b, alu_imm_val, alu_imm, alu_func}), 128'(0));
    chk("rst_rsp_data", 128'(rsp_data), 128'(16'h0));
    dbg_all_zero("rst_dbg");

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].c, 0, vecs[i].exp);
    end

    // Response backpressure with a command queued behind it that reads the stalled result
    c1 = '{4'd1, 1'b1, 16'h0100, 3'd2, 3'd0, 3'd6};
    c2 = '{4'd1, 1'b0, 16'h0000, 3'd3, 3'd2, 3'd2};
    e1 = alu_fn(model[c1.ra], model[c1.rb], c1.imm_val, c1.imm, c1.func);
    rsp_ready = 1'b0;
    offer(c1);
    wait_accept(t1, ok);
    if (ok) begin
      finish_cmd(c1, 10, e1, t1, 1'b1, c2, td);
      wait_accept(t2, ok);
      if (ok) begin
        chk("bp_accept_gap", 128'(t2 - td), 128'(CP));
        e2 = alu_fn(model[c2.ra], model[c2.rb], c2.imm_val, c2.imm, c2.func);
        finish_cmd(c2, 0, e2, t2, 1'b0, none, td);
        prev_done = td;
        have_prev = 1'b1;
      end
    end

    for (int n = 0; n < 30; n++) begin
      cmd_t        rc;
      logic [15:0] re;
      rc.func    = 4'($urandom_range(0, 7));
      rc.imm     = 1'($urandom_range(0, 1));
      rc.imm_val = 16'($urandom);
      rc.rd      = RW'($urandom_range(0, NREGS - 1));
      rc.ra      = RW'($urandom_range(0, NREGS - 1));
      rc.rb      = RW'($urandom_range(0, NREGS - 1));
      re = alu_fn(model[rc.ra], model[rc.rb], rc.imm_val, rc.imm, rc.func);
      run_cmd(rc, int'($urandom_range(0, 2)), re);
    end

    // Reset one cycle into EXEC: op discarded, no writeback, outputs back to reset values
    c1 = '{4'd0, 1'b1, 16'hAAAA, 3'd3, 3'd0, 3'd0};
    rsp_ready = 1'b1;
    offer(c1);
    wait_accept(t1, ok);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midop_rst_ctrl", 128'({cmd_ready, busy, rsp_valid, rsp_rd}), 128'({3'b100, 3'd0}));
    chk("midop_rst_alu", 128'({alu_a, alu_b, alu_imm_val, alu_imm, alu_func}), 128'(0));
    chk("midop_rst_data", 128'(rsp_data), 128'(16'h0));
    repeat (3) begin
      tick();
      chk("midop_rst_hold", 128'(rsp_valid), 128'(1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midop_post_rst", 128'({rsp_valid, busy, cmd_ready}), 128'(3'b001));
    end
    dbg_all_zero("midop_dbg");

    run_cmd('{4'd0, 1'b1, 16'h5A5A, 3'd3, 3'd0, 3'd0}, 0, 16'h5A5A);
    run_cmd('{4'd2, 1'b1, 16'h005A, 3'd4, 3'd0, 3'd3}, 1, 16'h5A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
